// File: rtl/register_file_arbiter.sv
// Two-requester arbiter in front of the single-port register file.
// Round-robin on contention, optional lock for read-modify-write sequences,
// lock released by the owner or by an idle timeout. Responses are
// registered one cycle after the transfer.
module register_file_arbiter #(
    parameter int ADDRESS_WIDTH  = 7,
    parameter int DATA_WIDTH     = 8,
    parameter int REGISTER_COUNT = 8,
    parameter int LOCK_TIMEOUT   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_0_valid,
    input  logic                     req_0_write,
    input  logic                     req_0_lock,
    input  logic [ADDRESS_WIDTH-1:0] req_0_address,
    input  logic [DATA_WIDTH-1:0]    req_0_data,
    input  logic                     req_1_valid,
    input  logic                     req_1_write,
    input  logic                     req_1_lock,
    input  logic [ADDRESS_WIDTH-1:0] req_1_address,
    input  logic [DATA_WIDTH-1:0]    req_1_data,
    output logic                     req_0_ready,
    output logic                     req_1_ready,
    output logic                     resp_0_valid,
    output logic [DATA_WIDTH-1:0]    resp_0_data,
    output logic                     resp_0_error,
    output logic                     resp_1_valid,
    output logic [DATA_WIDTH-1:0]    resp_1_data,
    output logic                     resp_1_error,
    output logic                     lock_timeout,
    output logic                     rf_write,
    output logic [ADDRESS_WIDTH-1:0] rf_address,
    output logic [DATA_WIDTH-1:0]    rf_input_data,
    input  logic [DATA_WIDTH-1:0]    rf_output_data
);

    localparam int                   CW        = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CW-1:0]        CNT_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [ADDRESS_WIDTH:0] REG_LIMIT = (ADDRESS_WIDTH + 1)'(REGISTER_COUNT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCKED_0 = 2'd1,
        LOCKED_1 = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_q, last_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    timeout_q, timeout_d;

    logic                    grant_0, grant_1, xfer, sel;
    logic                    sel_write, sel_lock, sel_in_range;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data, rsp_data;

    logic                    resp_0_valid_q, resp_1_valid_q;
    logic                    resp_0_error_q, resp_1_error_q;
    logic [DATA_WIDTH-1:0]   resp_0_data_q, resp_1_data_q;

    // State, round-robin pointer, lock counter and timeout pulse registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state: transfers set the lock state; an idle owner times out
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        if (xfer) begin
            // In a locked state only the owner can transfer, so sel is the owner
            last_d = sel;
            cnt_d  = '0;
            if (sel_lock) state_d = sel ? LOCKED_1 : LOCKED_0;
            else          state_d = IDLE;
        end else if (state_q != IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d   = IDLE;
                cnt_d     = '0;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Grants: lock owner only when locked, otherwise round-robin on a tie
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (!reset) begin
            case (state_q)
                LOCKED_0: grant_0 = req_0_valid;
                LOCKED_1: grant_1 = req_1_valid;
                default: begin
                    grant_0 = req_0_valid & (~req_1_valid | last_q);
                    grant_1 = req_1_valid & (~req_0_valid | ~last_q);
                end
            endcase
        end
    end

    // Selected request and register file forwarding
    always_comb begin
        xfer         = grant_0 | grant_1;
        sel          = grant_1;
        sel_write    = sel ? req_1_write   : req_0_write;
        sel_lock     = sel ? req_1_lock    : req_0_lock;
        sel_addr     = sel ? req_1_address : req_0_address;
        sel_data     = sel ? req_1_data    : req_0_data;
        sel_in_range = {1'b0, sel_addr} < REG_LIMIT;
        rsp_data     = '0;
        if (sel_in_range) rsp_data = sel_write ? sel_data : rf_output_data;
        rf_write      = xfer & sel_write & sel_in_range;
        rf_address    = xfer ? sel_addr : '0;
        rf_input_data = xfer ? sel_data : '0;
    end

    // Response registers, captured on the transfer edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_0_valid_q <= 1'b0;
            resp_1_valid_q <= 1'b0;
            resp_0_error_q <= 1'b0;
            resp_1_error_q <= 1'b0;
            resp_0_data_q  <= '0;
            resp_1_data_q  <= '0;
        end else begin
            resp_0_valid_q <= grant_0;
            resp_1_valid_q <= grant_1;
            if (grant_0) begin
                resp_0_data_q  <= rsp_data;
                resp_0_error_q <= ~sel_in_range;
            end
            if (grant_1) begin
                resp_1_data_q  <= rsp_data;
                resp_1_error_q <= ~sel_in_range;
            end
        end
    end

    assign req_0_ready  = grant_0;
    assign req_1_ready  = grant_1;
    assign resp_0_valid = resp_0_valid_q;
    assign resp_1_valid = resp_1_valid_q;
    assign resp_0_data  = resp_0_data_q;
    assign resp_1_data  = resp_1_data_q;
    assign resp_0_error = resp_0_error_q;
    assign resp_1_error = resp_1_error_q;
    assign lock_timeout = timeout_q;

endmodule

// File: doc/register_file_arbiter.md
# register_file_arbiter

Two-requester arbiter sharing the single port of the 8 × 8-bit register file unit. It grants one access per cycle, round-robin on contention, and forwards the granted access to the register file. It returns a registered response one cycle later. A requester may lock the file for atomic read-modify-write sequences; a timeout ends any lock the owner stops using. It sits between the core's sequencer and debug/config master and the register file.

## Interface
- ADDRESS_WIDTH, 7, register file address width
- DATA_WIDTH, 8, register data width
- REGISTER_COUNT, 8, implemented registers; valid addresses 0..REGISTER_COUNT-1
- LOCK_TIMEOUT, 16, idle owner cycles before a lock is force-released (≥1)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- req_0_valid / req_1_valid  in  1  access request
- req_0_write / req_1_write  in  1  1 = write, 0 = read
- req_0_lock / req_1_lock  in  1  acquire/hold lock with this access
- req_0_address / req_1_address  in  ADDRESS_WIDTH  register address
- req_0_data / req_1_data  in  DATA_WIDTH  write data
- req_0_ready / req_1_ready  out  1  grant (combinational)
- resp_0_valid / resp_1_valid  out  1  one-cycle response pulse
- resp_0_data / resp_1_data  out  DATA_WIDTH  read data, or echoed write data
- resp_0_error / resp_1_error  out  1  address out of range
- lock_timeout  out  1  one-cycle pulse: lock force-released
- rf_write  out  1  register file write enable
- rf_address  out  ADDRESS_WIDTH  register file address
- rf_input_data  out  DATA_WIDTH  register file write data
- rf_output_data  in  DATA_WIDTH  register file combinational read data

## Operation
- Transfer on requester i is req_i_valid & req_i_ready. At most one transfer per cycle.
- States: IDLE, LOCKED_0, LOCKED_1. Round-robin pointer last_served resets to 1, so requester 0 wins the first tie.
- IDLE grant rules:
  - Single valid requester is granted.
  - Both valid: the requester ≠ last_served is granted.
- LOCKED_i: only requester i can be granted; the other's ready = 0.
- Every transfer sets last_served to the granted index.
- A transfer with lock = 1 moves to LOCKED_i, or stays there.
- A transfer by the owner with lock = 0 completes, then moves to IDLE.
- Owner dropping valid does not release the lock.
- Timeout counter:
  - Width clog2(LOCK_TIMEOUT+1); cleared on entry to LOCKED_i and on every owner transfer.
  - Increments each locked cycle without an owner transfer.
  - If the counter equals LOCK_TIMEOUT-1 with no owner transfer, next state is IDLE and lock_timeout pulses next cycle.
- Owner transfer in the timeout cycle takes precedence: no timeout, counter cleared.
- Forwarding:
  - rf_address and rf_input_data carry the granted request.
  - rf_write = transfer & write & in-range.
  - With no grant, all rf_* outputs are 0.
- Out-of-range address (≥ REGISTER_COUNT):
  - Transfer still completes and updates lock state and pointer.
  - rf_write = 0; response has error = 1, data = 0.
- Response registered on the transfer edge:
  - Read: resp_i_data = rf_output_data sampled that edge.
  - Write: resp_i_data = req_i_data.
  - Non-transferring requester's resp_valid = 0.

## Timing
- Grant: combinational, same cycle as valid; zero-cycle request latency; one transfer per cycle sustained.
- Response: resp_i_valid/data/error exactly 1 cycle after the transfer; back-to-back transfers give back-to-back pulses.
- Read-after-write to the same register on consecutive cycles returns the new value: the write lands on edge N and the read samples at edge N+1.
- Reset (asserted anytime, including mid-lock):
  - State IDLE, last_served = 1, counter = 0.
  - All resp_*, lock_timeout = 0.
  - ready_0/1 forced 0 while reset is high.
  - Pending responses are discarded.
- Requester must hold valid/address/data/write/lock stable until ready; the arbiter does not register requests.

## Test plan
- Reset, then req_0 reads addr 3 after req_1 writes 0x5A to addr 3 (one transfer per cycle) -> resp_1_valid with data 0x5A, then resp_0_data = 0x5A; all outputs 0 during reset.
- Both requesters valid for 4 cycles, reads of addr 0 and addr 1 -> grants alternate 0,1,0,1; one resp pulse per cycle to the matching requester.
- req_0 locked read of addr 2 (value 0x10), then 3 contended cycles, then unlocked write 0x11 -> req_1_ready = 0 throughout; after the write, req_1 is granted next cycle and reads 0x11.
- req_0 locks then goes idle with req_1 valid, LOCK_TIMEOUT = 16 -> lock_timeout pulses; req_1 granted on the cycle after the 16th idle cycle; an owner transfer in the 16th cycle prevents the timeout.
- req_1 writes 0x77 to addr 9 -> rf_write = 0, resp_1_error = 1, resp_1_data = 0; registers unchanged.
- Reset asserted while LOCKED_1 with a pending read -> no response pulse; after release, IDLE, and a tie grants requester 0.
